// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of NUM_REQ ALU requests into one registered execute stage.
// Define ALU_ARB_PERF_EN to add perf_issue_cnt / perf_stall_cnt counters.
module alu_issue_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 6,
   localparam int IDW    = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [3*NUM_REQ-1:0]   req_funct3,
   input  logic [NUM_REQ-1:0]     req_funct7,
   input  logic [32*NUM_REQ-1:0]  req_a,
   input  logic [32*NUM_REQ-1:0]  req_b,
   input  logic [TAG_W*NUM_REQ-1:0] req_tag,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [31:0]            res_data,
   output logic [IDW-1:0]         res_id,
`ifdef ALU_ARB_PERF_EN
   output logic [31:0]            perf_issue_cnt,
   output logic [31:0]            perf_stall_cnt,
`endif
   output logic [TAG_W-1:0]       res_tag
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t state;
   logic [IDW-1:0] rr_ptr, gidx, idx;
   logic found, armed, hs;
   logic [2:0] f3;
   logic f7;
   logic [31:0] a, b, b_eff;
   always_comb begin
      gidx = '0;
      idx = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gidx = idx;
         end
      end
   end
   // armed keeps req_ready low after reset release until the first clock edge
   assign req_ready = (found && armed && (state == EMPTY || res_ready)) ? NUM_REQ'(1) << gidx : '0;
   assign hs = |req_ready;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
         armed <= 1'b0;
         rr_ptr <= '0;
         f3 <= '0;
         f7 <= 1'b0;
         a <= '0;
         b <= '0;
         res_id <= '0;
         res_tag <= '0;
      end else begin
         armed <= 1'b1;
         if (hs) begin
            state <= FULL;
            rr_ptr <= (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            f3 <= req_funct3[3*gidx +: 3];
            f7 <= req_funct7[gidx];
            a <= req_a[32*gidx +: 32];
            b <= req_b[32*gidx +: 32];
            res_id <= gidx;
            res_tag <= req_tag[TAG_W*gidx +: TAG_W];
         end else if (res_ready) begin
            state <= EMPTY;
         end
      end
   end
   assign res_valid = (state == FULL);
   assign b_eff = (f3[1:0] == 2'b01) ? {27'b0, b[4:0]} : b;
   always_comb begin
      case (f3)
         3'b000: res_data = f7 ? a - b_eff : a + b_eff;
         3'b001: res_data = a << b_eff[4:0];
         3'b010: res_data = {31'b0, $signed(a) < $signed(b_eff)};
         3'b011: res_data = {31'b0, a < b_eff};
         3'b100: res_data = a ^ b_eff;
         3'b101: res_data = f7 ? 32'($signed(a) >>> b_eff[4:0]) : a >> b_eff[4:0];
         3'b110: res_data = a | b_eff;
         default: res_data = a & b_eff;
      endcase
   end
`ifdef ALU_ARB_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (hs) perf_issue_cnt <= perf_issue_cnt + 1'b1;
         if (|req_valid && !hs) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed vectors for arbitration, backpressure, ALU ops and async reset.
module tb_alu_issue_arbiter;
   localparam int NUM_REQ = 4;
   localparam int TAG_W = 6;
   logic clk = 1'b0;
   logic rst;
   logic [NUM_REQ-1:0] req_valid, req_ready, req_funct7;
   logic [3*NUM_REQ-1:0] req_funct3;
   logic [32*NUM_REQ-1:0] req_a, req_b;
   logic [TAG_W*NUM_REQ-1:0] req_tag;
   logic res_valid, res_ready;
   logic [31:0] res_data;
   logic [1:0] res_id;
   logic [TAG_W-1:0] res_tag;
   int n_chk = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   alu_issue_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_funct3(req_funct3), .req_funct7(req_funct7), .req_a(req_a), .req_b(req_b),
      .req_tag(req_tag), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id), .res_tag(res_tag)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic set_slot(input int s, input logic [2:0] f3, input logic f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
      req_funct3[3*s +: 3] = f3;
      req_funct7[s] = f7;
      req_a[32*s +: 32] = a;
      req_b[32*s +: 32] = b;
      req_tag[TAG_W*s +: TAG_W] = t;
   endtask
   task automatic issue_one(input int s, input logic [2:0] f3, input logic f7, input logic [31:0] a,
                            input logic [31:0] b, input logic [TAG_W-1:0] t, input logic [31:0] exp);
      int c;
      req_valid = '0;
      set_slot(s, f3, f7, a, b, t);
      req_valid[s] = 1'b1;
      c = 0;
      #1;
      while (!req_ready[s] && c < 8) begin
         @(negedge clk);
         #1;
         c++;
      end
      check("alu_grant", 32'(req_ready), 32'(1 << s));
      @(negedge clk);
      req_valid = '0;
      check("alu_valid", 32'(res_valid), 32'd1);
      check("alu_data", res_data, exp);
      check("alu_tag", 32'(res_tag), 32'(t));
   endtask
   initial begin
      int g;
      rst = 1'b1;
      res_ready = 1'b1;
      req_valid = '0;
      req_funct3 = '0;
      req_funct7 = '0;
      req_a = '0;
      req_b = '0;
      req_tag = '0;
      set_slot(0, 3'b000, 1'b0, 32'd5, 32'd7, 6'd3);
      req_valid = 4'b0001;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_data", res_data, 32'd0);
      check("rst_id", 32'(res_id), 32'd0);
      check("rst_tag", 32'(res_tag), 32'd0);
      rst = 1'b0;
      #1 check("release_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("first_grant", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("first_valid", 32'(res_valid), 32'd1);
      check("first_data", res_data, 32'd12);
      check("first_id", 32'(res_id), 32'd0);
      check("first_tag", 32'(res_tag), 32'd3);
      // rr_ptr is 1 now; every slot stays valid so the pointer alone picks the winner
      for (int i = 0; i < NUM_REQ; i++) set_slot(i, 3'b000, 1'b0, 32'(10 * i), 32'(i), 6'(8 + i));
      req_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         g = (1 + k) % 4;
         #1 check("rr_grant", 32'(req_ready), 32'(1 << g));
         @(negedge clk);
         check("rr_valid", 32'(res_valid), 32'd1);
         check("rr_id", 32'(res_id), 32'(g));
         check("rr_data", res_data, 32'(11 * g));
         check("rr_tag", 32'(res_tag), 32'(8 + g));
      end
      req_valid = 4'b0110;
      res_ready = 1'b0;
      repeat (3) begin
         #1 check("bp_ready", 32'(req_ready), 32'd0);
         check("bp_valid", 32'(res_valid), 32'd1);
         check("bp_id", 32'(res_id), 32'd0);
         check("bp_data", res_data, 32'd0);
         check("bp_tag", 32'(res_tag), 32'd8);
         @(negedge clk);
      end
      res_ready = 1'b1;
      #1 check("bp_release", 32'(req_ready), 32'd2);
      @(negedge clk);
      req_valid = '0;
      check("bp_next_id", 32'(res_id), 32'd1);
      check("bp_next_data", res_data, 32'd11);
      check("bp_next_valid", 32'(res_valid), 32'd1);
      issue_one(1, 3'b101, 1'b1, 32'h8000_0000, 32'h0000_0024, 6'd1, 32'hF800_0000);
      issue_one(3, 3'b000, 1'b1, 32'd3, 32'd5, 6'd2, 32'hFFFF_FFFE);
      issue_one(0, 3'b001, 1'b0, 32'd1, 32'd33, 6'd4, 32'd2);
      issue_one(2, 3'b101, 1'b0, 32'h8000_0000, 32'd4, 6'd5, 32'h0800_0000);
      issue_one(1, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 6'd6, 32'd1);
      issue_one(1, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 6'd7, 32'd0);
      issue_one(3, 3'b100, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 6'd9, 32'h0000_0FF0);
      issue_one(0, 3'b110, 1'b0, 32'h0000_00F0, 32'h0000_000F, 6'd10, 32'h0000_00FF);
      issue_one(2, 3'b111, 1'b0, 32'h0000_00F0, 32'h0000_003C, 6'd11, 32'h0000_0030);
      issue_one(2, 3'b000, 1'b0, 32'd1, 32'd1, 6'd12, 32'd2);
      res_ready = 1'b0;
      set_slot(0, 3'b000, 1'b0, 32'd20, 32'd22, 6'd13);
      set_slot(3, 3'b000, 1'b0, 32'd30, 32'd33, 6'd14);
      req_valid = 4'b1001;
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'd1);
      rst = 1'b1;
      #1 check("async_valid", 32'(res_valid), 32'd0);
      check("async_data", res_data, 32'd0);
      check("async_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      res_ready = 1'b1;
      #1 check("rerelease_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("rr_reset_grant", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("rr_reset_id", 32'(res_id), 32'd0);
      check("rr_reset_data", res_data, 32'd42);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
